// File: rtl/ddr3_ui_pkg.sv
// Shared constants, command encodings and execution-FSM states for the DDR3 UI responder.
package ddr3_ui_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam int UI_DATA_W   = 32;
    localparam int UI_ADDR_W   = 29;
    localparam int BURST_BEATS = 2;

    localparam logic [1:0] ERR_ILLEGAL_CMD = 2'b01;
    localparam logic [1:0] ERR_WDF_END     = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR0,
        ST_WR1,
        ST_RD0,
        ST_RD1
    } ui_state_e;

    // Illegal commands map to IDLE so the caller can drop them without a state change.
    function automatic ui_state_e dispatch_state(input logic [2:0] cmd);
        ui_state_e st;
        case (cmd)
            CMD_WR:  st = ST_WR0;
            CMD_RD:  st = ST_RD0;
            default: st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/ui_sync_fifo.sv
// Single-clock show-ahead FIFO with registered empty/full and a look-ahead full for registered ready flags.
module ui_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             ui_clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full_next
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] ram [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg, count_next;
    logic             empty_reg, full_reg;
    logic             push_ok, pop_ok;

    assign push_ok = push & ~full_reg;
    assign pop_ok  = pop & ~empty_reg;

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    assign full_next = (count_next == (AW+1)'(DEPTH));

    always_ff @(posedge ui_clk) begin
        if (push_ok) begin
            ram[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            empty_reg  <= 1'b1;
            full_reg   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= full_next;
        end
    end

    assign pop_data = ram[rd_ptr_reg];
    assign empty    = empty_reg;

endmodule

// File: rtl/ddr3_ui_responder.sv
// Memory-controller stand-in for the 32-bit DDR3 app/UI port: queues commands and write
// beats, executes bursts in order against an internal RAM, and returns fixed-latency read bursts.
module ddr3_ui_responder
    import ddr3_ui_pkg::*;
#(
    parameter int MEM_AW           = 10,
    parameter int CMD_DEPTH        = 8,
    parameter int WDF_DEPTH        = 16,
    parameter int RD_LATENCY       = 4,
    parameter int INIT_CYCLES      = 64,
    parameter int RDY_STALL_PERIOD = 0
) (
    input  logic        ui_clk,
    input  logic        rst,
    output logic        o_app_phy_init_done,
    input  logic        i_app_en,
    input  logic [2:0]  i_app_cmd,
    input  logic [28:0] i_app_addr,
    output logic        o_app_rdy,
    input  logic        i_app_wdf_wren,
    input  logic        i_app_wdf_end,
    input  logic [31:0] i_app_wdf_data,
    output logic        o_app_wdf_rdy,
    output logic        o_app_rd_data_valid,
    output logic        o_app_rd_data_end,
    output logic [31:0] o_app_rd_data,
    output logic        o_err,
    output logic [1:0]  o_err_code
);

    localparam int IDX_W  = MEM_AW - 1;
    localparam int CMD_W  = 3 + IDX_W;
    localparam int WDF_W  = UI_DATA_W + 1;
    localparam int INIT_W = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;

    logic                 init_done_reg, init_done_next;
    logic [INIT_W-1:0]    init_cnt_reg, init_cnt_next;
    logic                 app_rdy_reg, app_wdf_rdy_reg, stall_next;
    logic                 cmd_push, cmd_pop, cmd_empty, cmd_full_next;
    logic [CMD_W-1:0]     cmd_q;
    logic                 wdf_push, wdf_pop, wdf_empty, wdf_full_next;
    logic [WDF_W-1:0]     wdf_q;
    ui_state_e            state_reg, dispatch;
    logic [IDX_W-1:0]     base_reg;
    logic                 mem_we, rd_issue;
    logic [MEM_AW-1:0]    mem_addr;
    logic [1:0]           err_set, err_code_reg;
    logic                 err_reg;
    logic [UI_DATA_W-1:0] mem [0:(1<<MEM_AW)-1];
    logic [UI_DATA_W-1:0] mem_q;
    logic [RD_LATENCY-1:0] v_pipe_reg, e_pipe_reg;
    logic [UI_DATA_W-1:0] d_pipe_reg [1:RD_LATENCY-1];
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{i_app_addr[UI_ADDR_W-1:MEM_AW+2], i_app_addr[2:0]};

    assign init_cnt_next  = (init_cnt_reg == INIT_W'(INIT_CYCLES)) ? init_cnt_reg : init_cnt_reg + 1'b1;
    assign init_done_next = init_done_reg | (init_cnt_next == INIT_W'(INIT_CYCLES));

    generate
        if (RDY_STALL_PERIOD != 0) begin : g_stall
            localparam int SW = (RDY_STALL_PERIOD > 1) ? $clog2(RDY_STALL_PERIOD) : 1;
            logic [SW-1:0] stall_cnt_reg, stall_cnt_next;
            assign stall_cnt_next = (stall_cnt_reg == SW'(RDY_STALL_PERIOD - 1)) ? '0 : stall_cnt_reg + SW'(1);
            assign stall_next     = (stall_cnt_next == SW'(RDY_STALL_PERIOD - 1));
            always_ff @(posedge ui_clk) begin
                if (rst) stall_cnt_reg <= '0;
                else     stall_cnt_reg <= stall_cnt_next;
            end
        end else begin : g_nostall
            assign stall_next = 1'b0;
        end
    endgenerate

    // Ready flags are computed from next-cycle FIFO occupancy so they stay purely registered.
    always_ff @(posedge ui_clk) begin
        if (rst) begin
            init_cnt_reg    <= '0;
            init_done_reg   <= 1'b0;
            app_rdy_reg     <= 1'b0;
            app_wdf_rdy_reg <= 1'b0;
        end else begin
            init_cnt_reg    <= init_cnt_next;
            init_done_reg   <= init_done_next;
            app_rdy_reg     <= init_done_next & ~cmd_full_next & ~stall_next;
            app_wdf_rdy_reg <= init_done_next & ~wdf_full_next & ~stall_next;
        end
    end

    assign cmd_push = i_app_en & app_rdy_reg;
    assign wdf_push = i_app_wdf_wren & app_wdf_rdy_reg;

    ui_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .ui_clk    (ui_clk),
        .rst       (rst),
        .push      (cmd_push),
        .push_data ({i_app_cmd, i_app_addr[MEM_AW+1:3]}),
        .pop       (cmd_pop),
        .pop_data  (cmd_q),
        .empty     (cmd_empty),
        .full_next (cmd_full_next)
    );

    ui_sync_fifo #(.WIDTH(WDF_W), .DEPTH(WDF_DEPTH)) u_wdf_fifo (
        .ui_clk    (ui_clk),
        .rst       (rst),
        .push      (wdf_push),
        .push_data ({i_app_wdf_end, i_app_wdf_data}),
        .pop       (wdf_pop),
        .pop_data  (wdf_q),
        .empty     (wdf_empty),
        .full_next (wdf_full_next)
    );

    assign dispatch = dispatch_state(cmd_q[CMD_W-1 -: 3]);
    assign mem_addr = {base_reg, (state_reg == ST_WR1) || (state_reg == ST_RD1)};

    // The last cycle of each burst also pops the next command so bursts stream back to back.
    always_comb begin
        cmd_pop  = 1'b0;
        wdf_pop  = 1'b0;
        mem_we   = 1'b0;
        rd_issue = 1'b0;
        err_set  = 2'b00;
        case (state_reg)
            ST_IDLE: cmd_pop = ~cmd_empty;
            ST_WR0: begin
                wdf_pop = ~wdf_empty;
                mem_we  = ~wdf_empty;
                if (!wdf_empty && wdf_q[UI_DATA_W]) err_set = ERR_WDF_END;
            end
            ST_WR1: begin
                wdf_pop = ~wdf_empty;
                mem_we  = ~wdf_empty;
                cmd_pop = ~wdf_empty & ~cmd_empty;
                if (!wdf_empty && !wdf_q[UI_DATA_W]) err_set = ERR_WDF_END;
            end
            ST_RD0: rd_issue = 1'b1;
            ST_RD1: begin
                rd_issue = 1'b1;
                cmd_pop  = ~cmd_empty;
            end
            default: ;
        endcase
        if (cmd_pop && dispatch == ST_IDLE) err_set = err_set | ERR_ILLEGAL_CMD;
    end

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            base_reg  <= '0;
        end else begin
            if (cmd_pop) base_reg <= cmd_q[IDX_W-1:0];
            case (state_reg)
                ST_IDLE: if (cmd_pop) state_reg <= dispatch;
                ST_WR0:  if (wdf_pop) state_reg <= wdf_q[UI_DATA_W] ? ST_IDLE : ST_WR1;
                ST_WR1:  if (wdf_pop) state_reg <= cmd_pop ? dispatch : ST_IDLE;
                ST_RD0:  state_reg <= ST_RD1;
                ST_RD1:  state_reg <= cmd_pop ? dispatch : ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ui_clk) begin
        if (mem_we)   mem[mem_addr] <= wdf_q[UI_DATA_W-1:0];
        if (rd_issue) mem_q <= mem[mem_addr];
    end

    // Data is read at issue time so a following write cannot overtake an in-flight read.
    always_ff @(posedge ui_clk) begin
        if (rst) begin
            v_pipe_reg <= '0;
            e_pipe_reg <= '0;
            for (int i = 1; i < RD_LATENCY; i++) d_pipe_reg[i] <= '0;
        end else begin
            v_pipe_reg    <= {v_pipe_reg[RD_LATENCY-2:0], rd_issue};
            e_pipe_reg    <= {e_pipe_reg[RD_LATENCY-2:0], rd_issue & (state_reg == ST_RD1)};
            d_pipe_reg[1] <= mem_q;
            for (int i = 2; i < RD_LATENCY; i++) d_pipe_reg[i] <= d_pipe_reg[i-1];
        end
    end

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            err_code_reg <= 2'b00;
            err_reg      <= 1'b0;
        end else begin
            err_code_reg <= err_code_reg | err_set;
            err_reg      <= |(err_code_reg | err_set);
        end
    end

    assign o_app_phy_init_done = init_done_reg;
    assign o_app_rdy           = app_rdy_reg;
    assign o_app_wdf_rdy       = app_wdf_rdy_reg;
    assign o_app_rd_data_valid = v_pipe_reg[RD_LATENCY-1];
    assign o_app_rd_data_end   = e_pipe_reg[RD_LATENCY-1];
    assign o_app_rd_data       = d_pipe_reg[RD_LATENCY-1];
    assign o_err               = err_reg;
    assign o_err_code          = err_code_reg;

endmodule

// File: tb/tb_ddr3_ui_responder.sv
// Self-checking bench: a default responder and a ready-stall responder share one stimulus path.
module tb_ddr3_ui_responder;
    import ddr3_ui_pkg::*;

    localparam int RD_LAT = 4;
    localparam int INIT   = 64;

    logic ui_clk = 1'b0;
    logic rst    = 1'b1;
    always #5 ui_clk = ~ui_clk;

    logic        sel = 1'b0;
    logic        app_en = 1'b0, wren = 1'b0, wend = 1'b0;
    logic [2:0]  app_cmd = 3'b000;
    logic [28:0] app_addr = '0;
    logic [31:0] wdata = '0;

    logic        init0, rdy0, wrdy0, v0, e0, err0;
    logic        init1, rdy1, wrdy1, v1, e1, err1;
    logic [31:0] d0, d1;
    logic [1:0]  ec0, ec1;

    ddr3_ui_responder dut0 (
        .ui_clk(ui_clk), .rst(rst), .o_app_phy_init_done(init0),
        .i_app_en(app_en & ~sel), .i_app_cmd(app_cmd), .i_app_addr(app_addr), .o_app_rdy(rdy0),
        .i_app_wdf_wren(wren & ~sel), .i_app_wdf_end(wend), .i_app_wdf_data(wdata), .o_app_wdf_rdy(wrdy0),
        .o_app_rd_data_valid(v0), .o_app_rd_data_end(e0), .o_app_rd_data(d0),
        .o_err(err0), .o_err_code(ec0)
    );

    ddr3_ui_responder #(.RDY_STALL_PERIOD(3)) dut1 (
        .ui_clk(ui_clk), .rst(rst), .o_app_phy_init_done(init1),
        .i_app_en(app_en & sel), .i_app_cmd(app_cmd), .i_app_addr(app_addr), .o_app_rdy(rdy1),
        .i_app_wdf_wren(wren & sel), .i_app_wdf_end(wend), .i_app_wdf_data(wdata), .o_app_wdf_rdy(wrdy1),
        .o_app_rd_data_valid(v1), .o_app_rd_data_end(e1), .o_app_rd_data(d1),
        .o_err(err1), .o_err_code(ec1)
    );

    logic        rdy, wrdy, rd_valid, rd_end;
    logic [31:0] rd_data;
    assign rdy      = sel ? rdy1  : rdy0;
    assign wrdy     = sel ? wrdy1 : wrdy0;
    assign rd_valid = sel ? v1    : v0;
    assign rd_end   = sel ? e1    : e0;
    assign rd_data  = sel ? d1    : d0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed { logic [31:0] d; logic e; } beat_t;
    beat_t sb[$];
    beat_t mon_x;

    typedef struct { logic [28:0] wa; logic [28:0] ra; logic [31:0] x0; logic [31:0] x1; } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge ui_clk) begin
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got data %08h end %0b, expected no beat", rd_data, rd_end);
            end else begin
                mon_x = sb.pop_front();
                $display("beat dut%0d data=%08h end=%0b", sel, rd_data, rd_end);
                chk("rd_data", {32'd0, rd_data}, {32'd0, mon_x.d});
                chk("rd_end", {63'd0, rd_end}, {63'd0, mon_x.e});
            end
        end
    end

    task automatic send_cmd(input logic [2:0] c, input logic [28:0] a);
        int n = 0;
        @(negedge ui_clk);
        app_en = 1'b1; app_cmd = c; app_addr = a;
        while (rdy !== 1'b1 && n < 200) begin @(negedge ui_clk); n++; end
        if (n >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL cmd_timeout: got rdy=0, expected rdy=1 within 200 cycles");
        end
        @(posedge ui_clk); #1;
        app_en = 1'b0;
        $display("cmd %03b addr %07h", c, a);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic e);
        int n = 0;
        @(negedge ui_clk);
        wren = 1'b1; wdata = d; wend = e;
        while (wrdy !== 1'b1 && n < 200) begin @(negedge ui_clk); n++; end
        if (n >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL wdf_timeout: got wdf_rdy=0, expected wdf_rdy=1 within 200 cycles");
        end
        @(posedge ui_clk); #1;
        wren = 1'b0;
        $display("wbeat data %08h end %0b", d, e);
    endtask

    task automatic do_write(input logic [28:0] a, input logic [31:0] x0, input logic [31:0] x1);
        send_cmd(CMD_WR, a);
        send_beat(x0, 1'b0);
        send_beat(x1, 1'b1);
    endtask

    task automatic do_read(input logic [28:0] a, input logic [31:0] x0, input logic [31:0] x1);
        sb.push_back({x0, 1'b0});
        sb.push_back({x1, 1'b1});
        send_cmd(CMD_RD, a);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge ui_clk); n++; end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int p;
        logic [11:0] rs, ws;

        for (int i = 0; i < 8; i++) begin
            tbl[i].wa = 29'(i << 3);
            tbl[i].ra = 29'(i << 3);
            tbl[i].x0 = 32'(2 * i);
            tbl[i].x1 = 32'(2 * i + 1);
        end
        tbl[8] = '{29'h1048, 29'h0048, 32'hDEAD_0012, 32'hDEAD_0013};
        tbl[9] = '{29'h0FF8, 29'h0FFF, 32'hBEEF_03FE, 32'hBEEF_03FF};

        repeat (3) @(posedge ui_clk);
        #1;
        chk("reset_outs0", {init0, rdy0, wrdy0, v0, e0, err0, ec0, d0}, 64'd0);
        chk("reset_outs1", {init1, rdy1, wrdy1, v1, e1, err1, ec1, d1}, 64'd0);

        @(negedge ui_clk);
        rst = 1'b0;
        app_en = 1'b1; app_cmd = CMD_WR; app_addr = 29'h28;
        for (int cyc = 1; cyc <= INIT; cyc++) begin
            @(posedge ui_clk); #1;
            chk("init_flags", {61'd0, init0, rdy0, wrdy0}, (cyc >= INIT) ? 64'd7 : 64'd0);
        end
        @(posedge ui_clk); #1;
        app_en = 1'b0;
        $display("cmd 000 addr 0000028 (held through init)");
        send_beat(32'hA5A5_0001, 1'b0);
        send_beat(32'hA5A5_0002, 1'b1);
        repeat (4) @(posedge ui_clk);

        do_read(29'h28, 32'hA5A5_0001, 32'hA5A5_0002);
        lat = 0;
        do begin
            @(posedge ui_clk); #1;
            lat++;
        end while (v0 !== 1'b1 && lat < 20);
        chk("rd_latency", 64'(lat), 64'(RD_LAT + 1));
        drain();

        for (int i = 0; i < 10; i++) do_write(tbl[i].wa, tbl[i].x0, tbl[i].x1);
        for (int i = 0; i < 10; i++) do_read(tbl[i].ra, tbl[i].x0, tbl[i].x1);
        drain();
        chk("err_after_stream", {61'd0, err0, ec0}, 64'd0);

        for (int k = 0; k < 16; k++) begin
            send_beat(32'h5000 + 32'(k), k[0]);
            if (k == 14) chk("wdf_rdy_after_15", {63'd0, wrdy}, 64'd1);
            if (k == 15) chk("wdf_rdy_after_16", {63'd0, wrdy}, 64'd0);
        end
        for (int j = 0; j < 8; j++) send_cmd(CMD_WR, 29'((16 + j) << 3));
        for (int j = 0; j < 8; j++) do_read(29'((16 + j) << 3), 32'h5000 + 32'(2 * j), 32'h5001 + 32'(2 * j));
        drain();
        chk("err_after_fill", {61'd0, err0, ec0}, 64'd0);

        send_cmd(CMD_WR, 29'(30 << 3));
        send_beat(32'h0000_0077, 1'b1);
        repeat (5) @(posedge ui_clk);
        #1;
        chk("err_truncated", {61'd0, err0, ec0}, 64'b110);
        send_cmd(3'b011, 29'd0);
        repeat (5) @(posedge ui_clk);
        #1;
        chk("err_both", {61'd0, err0, ec0}, 64'b111);
        do_write(29'(31 << 3), 32'h3131_0000, 32'h3131_0001);
        do_read(29'(31 << 3), 32'h3131_0000, 32'h3131_0001);
        drain();

        sel = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge ui_clk);
            rs[k] = rdy;
            ws[k] = wrdy;
        end
        p = -1;
        for (int k = 0; k < 3; k++) if (rs[k] == 1'b0 && p < 0) p = k;
        chk("stall_low_found", {63'd0, p >= 0}, 64'd1);
        if (p < 0) p = 0;
        for (int k = 0; k < 12; k++) begin
            chk("stall_rdy", {63'd0, rs[k]}, {63'd0, (k % 3) != p});
            chk("stall_wdf_rdy", {63'd0, ws[k]}, {63'd0, (k % 3) != p});
        end
        for (int i = 0; i < 8; i++) do_write(tbl[i].wa, ~tbl[i].x0, ~tbl[i].x1);
        for (int i = 0; i < 8; i++) do_read(tbl[i].ra, ~tbl[i].x0, ~tbl[i].x1);
        drain();
        chk("stall_err", {61'd0, err1, ec1}, 64'd0);

        do_read(tbl[0].ra, ~tbl[0].x0, ~tbl[0].x1);
        do_read(tbl[1].ra, ~tbl[1].x0, ~tbl[1].x1);
        lat = 0;
        while (v1 !== 1'b1 && lat < 50) begin @(negedge ui_clk); lat++; end
        chk("midread_valid_seen", {63'd0, v1}, 64'd1);
        rst = 1'b1;
        @(posedge ui_clk); #1;
        rst = 1'b0;
        sb.delete();
        $display("reset asserted mid-read");
        chk("after_rst_outs", {59'd0, v1, e1, init1, rdy1, wrdy1}, 64'd0);
        repeat (20) @(negedge ui_clk);
        chk("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
